rr_bus_arbiter: RTL
===================

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

Interface
REQ-001 Parameter NCLIENTS, default 8: number of bus masters, range 2..16.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 Parameter TIMEOUT, default 255: maximum stall cycles tolerated on a pending bus access, range 1..65535.
REQ-005 clk  in  1: single clock; all state updates on posedge.
REQ-006 Nrst  in  1: asynchronous, active-low reset.
REQ-007 bus_req  in  NCLIENTS: per-client request, held for the whole tenure.
REQ-008 bus_ack  out  NCLIENTS: registered one-hot grant.
REQ-009 c_addr  in  NCLIENTS*AW: per-client address; client i occupies slice [i*AW +: AW].
REQ-010 c_wdata  in  NCLIENTS*DW: per-client write data; client i occupies slice [i*DW +: DW].
REQ-011 c_rd, c_wr  in  NCLIENTS each: per-client read and write strobes.
REQ-012 bus_addr, bus_wdata, bus_rd, bus_wr  out  AW/DW/1/1: muxed master signals to the slave.
REQ-013 bus_ready  in  1: slave completion for the current beat.
REQ-014 bus_owner  out  clog2(NCLIENTS): index of the granted client; 0 when idle.
REQ-015 bus_busy  out  1: high while any grant is held.
REQ-016 bus_err  out  NCLIENTS: one-cycle timeout pulse to the offending client.

Function
REQ-017 States: IDLE (no grant), OWNED (one grant held), PENALTY (a timed-out owner is still requesting; no grant held).
REQ-018 Arbitration is round-robin: search begins at index ptr and wraps modulo NCLIENTS; the first index with bus_req high wins.
REQ-019 On each grant to client k, ptr <= (k+1) mod NCLIENTS.
REQ-020 IDLE: if any bus_req is high at an edge, bus_ack[winner] is set at that edge, giving one cycle of latency, and the state becomes OWNED.
REQ-021 OWNED: while bus_req[owner] is high, the grant is held regardless of other requests.
REQ-022 OWNED with bus_req[owner] low at an edge: that same edge drops the old ack and grants the next winner (zero bubble), or goes to IDLE if no request is pending.
REQ-023 bus_addr, bus_wdata, bus_rd and bus_wr are combinationally selected from the owner's slices (a true mux, not OR); all are zero when no grant is held.
REQ-024 Stall counter (16 bit): increments each cycle that a grant is held, (bus_rd|bus_wr) is 1 and bus_ready is 0; it clears on bus_ready, on no strobe, and on a grant change.
REQ-025 When the counter equals TIMEOUT at an edge: pulse bus_err[owner] for one cycle, drop the ack, and mask the owner.
REQ-026 After a timeout, the state becomes PENALTY if no other client is requesting; otherwise the next winner is granted on the same edge.
REQ-027 A masked client is excluded from arbitration until its bus_req is sampled low; the mask then clears.
REQ-028 A request dropped in the same cycle as the timeout edge is not masked.
REQ-029 bus_ack is always zero or one-hot; bus_busy equals |bus_ack.

Reset
REQ-030 Nrst low asynchronously forces bus_ack=0, bus_err=0, state=IDLE, ptr=0, counter=0 and mask=0; the muxed outputs therefore read zero.
REQ-031 Reset during a tenure abandons it; after Nrst rises, arbitration restarts from ptr=0 on the first edge.

Structure
REQ-032 A shared package holds the state enum (IDLE/OWNED/PENALTY), the counter width constant (16) and a clog2 function.
REQ-033 One sub-module, rr_pick: a combinational round-robin priority encoder with inputs (req & ~mask, ptr) and outputs (valid, index).

Verification
REQ-034 NCLIENTS=4; assert req=4'b1111 and drop each owner after 2 cycles -> grant order 0,1,2,3,0 with no idle cycle between tenures.
REQ-035 req[2] high only -> bus_ack=4'b0100 one cycle later; c_addr slice 2=0x1000 appears on bus_addr and bus_owner=2.
REQ-036 Owner 1 holds req for 20 cycles while req[0] is high -> ack stays 4'b0010 for all 20 cycles; client 0 is granted on the edge where req[1] drops.
REQ-037 TIMEOUT=5; owner 3 asserts bus_rd with bus_ready=0 -> bus_err[3] pulses on the 5th stall edge and ack drops; client 3 gets no grant while its req stays high; after its req drops and rises again, it is granted.
REQ-038 Nrst pulsed low mid-tenure -> bus_ack=0 and bus_rd=0 immediately (asynchronous); after release with req=4'b1010, client 1 wins.

Source files
------------

// File: rtl/rr_bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: arbitration states,
// stall counter width and a constant-foldable ceil(log2) helper.
package rr_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_PENALTY = 2'd2
    } arb_state_t;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_pick.sv
// Combinational round-robin priority encoder: first set bit of req found by
// searching upward from ptr and wrapping modulo N.
module rr_pick
    import rr_bus_arbiter_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]        req,
    input  logic [clog2(N)-1:0] ptr,
    output logic                valid,
    output logic [clog2(N)-1:0] index
);
    localparam int unsigned IW = clog2(N);

    always_comb begin : search
        int unsigned cand;
        valid = 1'b0;
        index = '0;
        cand  = 0;
        // Walk from the farthest offset back toward ptr so the nearest requester is written last.
        for (int unsigned i = N; i > 0; i--) begin
            cand = 32'(ptr) + i - 1;
            if (cand >= N) cand = cand - N;
            if (req[IW'(cand)]) begin
                valid = 1'b1;
                index = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with zero-bubble handover, per-client master mux,
// stall timeout with error pulse, and masking of timed-out clients.
module rr_bus_arbiter
    import rr_bus_arbiter_pkg::*;
#(
    parameter int unsigned NCLIENTS = 8,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       Nrst,
    input  logic [NCLIENTS-1:0]        bus_req,
    output logic [NCLIENTS-1:0]        bus_ack,
    input  logic [NCLIENTS*AW-1:0]     c_addr,
    input  logic [NCLIENTS*DW-1:0]     c_wdata,
    input  logic [NCLIENTS-1:0]        c_rd,
    input  logic [NCLIENTS-1:0]        c_wr,
    output logic [AW-1:0]              bus_addr,
    output logic [DW-1:0]              bus_wdata,
    output logic                       bus_rd,
    output logic                       bus_wr,
    input  logic                       bus_ready,
    output logic [clog2(NCLIENTS)-1:0] bus_owner,
    output logic                       bus_busy,
    output logic [NCLIENTS-1:0]        bus_err
);
    localparam int unsigned      IW     = clog2(NCLIENTS);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    arb_state_t          state, state_n;
    logic [NCLIENTS-1:0] ack_n, err_n, mask, mask_n, elig;
    logic [IW-1:0]       owner_n, ptr, ptr_n, win_idx;
    logic [CNT_W-1:0]    stall_cnt, stall_cnt_n, stall_inc;
    logic                win_valid, own_req, stall, timeout, rearb;

    assign bus_busy  = |bus_ack;
    assign own_req   = bus_req[bus_owner];
    assign stall     = bus_busy && (bus_rd || bus_wr) && !bus_ready;
    assign stall_inc = stall_cnt + CNT_W'(1);
    assign timeout   = (state == ST_OWNED) && stall && (stall_inc == TO_VAL);
    assign rearb     = (state != ST_OWNED) || timeout || !own_req;
    // A timing-out owner must not win the re-arbitration on its own timeout edge.
    assign elig      = bus_req & ~mask & ~(timeout ? bus_ack : '0);

    rr_pick #(.N(NCLIENTS)) u_pick (
        .req   (elig),
        .ptr   (ptr),
        .valid (win_valid),
        .index (win_idx)
    );

    always_comb begin
        state_n     = state;
        ack_n       = bus_ack;
        owner_n     = bus_owner;
        ptr_n       = ptr;
        err_n       = '0;
        mask_n      = mask & bus_req;
        stall_cnt_n = stall ? stall_inc : '0;
        if (timeout) begin
            err_n = bus_ack;
            if (own_req) mask_n = mask_n | bus_ack;
        end
        if (rearb) begin
            stall_cnt_n = '0;
            if (win_valid) begin
                state_n          = ST_OWNED;
                ack_n            = '0;
                ack_n[win_idx]   = 1'b1;
                owner_n          = win_idx;
                ptr_n            = (win_idx == IW'(NCLIENTS - 1)) ? '0 : win_idx + 1'b1;
            end else begin
                state_n = (|mask_n) ? ST_PENALTY : ST_IDLE;
                ack_n   = '0;
                owner_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            state     <= ST_IDLE;
            bus_ack   <= '0;
            bus_owner <= '0;
            ptr       <= '0;
            mask      <= '0;
            stall_cnt <= '0;
            bus_err   <= '0;
        end else begin
            state     <= state_n;
            bus_ack   <= ack_n;
            bus_owner <= owner_n;
            ptr       <= ptr_n;
            mask      <= mask_n;
            stall_cnt <= stall_cnt_n;
            bus_err   <= err_n;
        end
    end

    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        if (bus_busy) begin
            bus_addr  = c_addr[32'(bus_owner) * AW +: AW];
            bus_wdata = c_wdata[32'(bus_owner) * DW +: DW];
            bus_rd    = c_rd[bus_owner];
            bus_wr    = c_wr[bus_owner];
        end
    end

endmodule
